mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the output path; legal values 2..8.
REQ-002 Parameter W_DATA, default 8: width of each requester's data word and of the output.
REQ-003 Parameter MAX_HOLD, default 8: maximum consecutive cycles one requester may hold a grant; legal values 2..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous assert, active-low, synchronous-to-clk deassert supplied externally.
REQ-006 req  input  N_REQ  per-requester request level; bit i high = requester i wants the path.
REQ-007 done  input  N_REQ  per-requester release pulse; bit i sampled only while requester i is granted.
REQ-008 data_in  input  N_REQ*W_DATA  packed data words; word i is bits [i*W_DATA +: W_DATA].
REQ-009 gnt  output  N_REQ  registered one-hot grant, or all-zero.
REQ-010 sel  output  clog2(N_REQ)  registered index of current or most recent owner.
REQ-011 data_out  output  W_DATA  registered muxed data of the granted requester.
REQ-012 valid_out  output  1  registered; high when data_out carries a granted requester's word.

Function
REQ-013 FSM states: IDLE (no owner, gnt=0) and BUSY (one owner, gnt one-hot).
REQ-014 IDLE: if req != 0, the next clock enters BUSY with gnt set to the first requesting index strictly after last_owner, searching modulo N_REQ; otherwise stay in IDLE.
REQ-015 Grant latency: one cycle from req being sampled high in IDLE to gnt high.
REQ-016 On each entry to BUSY, last_owner and sel update to the granted index, and hold_cnt loads 1.
REQ-017 BUSY: each cycle data_out <= data_in word[sel] and valid_out <= 1; hold_cnt increments, saturating at MAX_HOLD.
REQ-018 BUSY exits to IDLE on the next clock when any of these is true: req[sel]=0, done[sel]=1, or hold_cnt=MAX_HOLD. Exit clears gnt and valid_out.
REQ-019 Every release inserts exactly one IDLE cycle with gnt=0 before any new grant, including a re-grant to the same requester.
REQ-020 Round-robin fairness: a requester that keeps req high is granted within N_REQ-1 intervening grants.
REQ-021 A sole requester that keeps req high is re-granted after its one-cycle IDLE gap, including after a MAX_HOLD preemption.
REQ-022 done or req changes on non-owner bits have no effect in BUSY; done bits are ignored in IDLE.
REQ-023 In IDLE, data_out holds its last value, valid_out=0, and sel holds last_owner.
REQ-024 Simultaneous req drop and done on the owner is a single release; they are not counted twice.
REQ-025 gnt is never multi-hot; valid_out=1 if and only if gnt != 0.

Reset
REQ-026 While rst=0, regardless of clk: state=IDLE, gnt=0, valid_out=0, data_out=0, sel=0, hold_cnt=0, last_owner=N_REQ-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-BUSY drops gnt and valid_out immediately (asynchronously); there is no residual grant after release.
REQ-028 First grant occurs no earlier than the first rising edge after rst returns high.

Verification
REQ-029 Reset, then req=4'b1111 held -> grant sequence is gnt 0001, 0010, 0100, 1000, 0001, ...; each grant lasts 8 cycles with one gnt=0 cycle between grants.
REQ-030 req=4'b0100 with data_in word2=8'hA5, held until a done[2] pulse on the 3rd grant cycle -> gnt=0100 for 3 cycles; data_out=8'hA5 and valid_out=1 during the grant; then gnt=0 and valid_out=0.
REQ-031 Owner=1 drops req while req[3] is high -> one IDLE cycle, then gnt=1000 and sel=3.
REQ-032 Sole requester 0 held for 20 cycles with MAX_HOLD=8 -> gnt=0001 high for cycles 1-8, low for cycle 9, high for cycles 10-17.
REQ-033 rst pulsed low mid-grant -> gnt=0, valid_out=0, data_out=0 with no clock edge; after release with req=4'b1010, the first grant is gnt=0010.
REQ-034 Random req, done, and data_in for 10000 cycles -> scoreboard confirms REQ-020 and REQ-025 hold, and data_out equals the granted word delayed by one cycle.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that grants one requester at a time and forwards its data word.
// A grant lasts until the owner drops req, pulses done, or reaches MAX_HOLD cycles.
module mux_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int W_DATA   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    input  logic [N_REQ*W_DATA-1:0]  data_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic [W_DATA-1:0]        data_out,
    output logic                     valid_out
);

    localparam int SEL_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_owner_q, last_owner_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic [W_DATA-1:0]   data_out_q, data_out_d;
    logic                valid_out_q, valid_out_d;

    logic [W_DATA-1:0]   words [N_REQ];
    logic [N_REQ-1:0]    req_rot;
    logic [SEL_W-1:0]    win_idx;
    logic                release_now;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = data_in[i*W_DATA +: W_DATA];
        end
    end

    // Rotate req so bit 0 is the requester just after last_owner; lowest set bit wins.
    always_comb begin
        req_rot = N_REQ'({req, req} >> (int'(last_owner_q) + 1));
        win_idx = last_owner_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_idx = SEL_W'((int'(last_owner_q) + 1 + k) % N_REQ);
            end
        end
    end

    assign release_now = !req[sel_q] || done[sel_q] ||
                         (hold_cnt_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        data_out_d   = data_out_q;
        valid_out_d  = valid_out_q;
        case (state_q)
            IDLE: begin
                gnt_d       = '0;
                valid_out_d = 1'b0;
                if (|req) begin
                    state_d      = BUSY;
                    gnt_d        = N_REQ'(1) << win_idx;
                    sel_d        = win_idx;
                    last_owner_d = win_idx;
                    hold_cnt_d   = CNT_W'(1);
                    data_out_d   = words[win_idx];
                    valid_out_d  = 1'b1;
                end
            end
            BUSY: begin
                // Any release goes through IDLE so there is always a one-cycle gap.
                if (release_now) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    valid_out_d = 1'b0;
                end else begin
                    data_out_d  = words[sel_q];
                    valid_out_d = 1'b1;
                    if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            sel_q        <= '0;
            last_owner_q <= SEL_W'(N_REQ - 1);
            hold_cnt_q   <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural owner/tenure model.
module tb_mux_rr_arbiter;

   localparam int N_REQ    = 4;
   localparam int W_DATA   = 8;
   localparam int MAX_HOLD = 8;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic [N_REQ-1:0]        req = '0;
   logic [N_REQ-1:0]        done = '0;
   logic [N_REQ*W_DATA-1:0] data_in = '0;
   logic [N_REQ-1:0]        gnt;
   logic [1:0]              sel;
   logic [W_DATA-1:0]       data_out;
   logic                    valid_out;

   int nTotal = 0;
   int nBad   = 0;
   bit chkEn  = 1'b0;

   mux_rr_arbiter #(.N_REQ(N_REQ), .W_DATA(W_DATA), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .done(done),
      .data_in(data_in),
      .gnt(gnt),
      .sel(sel),
      .data_out(data_out),
      .valid_out(valid_out)
   );

   // Free-running clock, period 10; inputs change 2 units after each rising edge
   always #5 clk = ~clk;

   // Single comparison point: every check bumps the counters printed in the summary
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act !== exp) begin
         nBad++;
         $display("[TB] FAIL %s: dut=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W_DATA-1:0] wordOf(input int i);
      return data_in[i*W_DATA +: W_DATA];
   endfunction

   // Behavioural model: who owns the path, who owned it last, and for how long
   int                mOwner = -1;
   int                mLast  = N_REQ - 1;
   int                mHold  = 0;
   int                mSel   = 0;
   int                mWin;
   logic [W_DATA-1:0] mData  = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mOwner = -1;
         mLast  = N_REQ - 1;
         mHold  = 0;
         mSel   = 0;
         mData  = '0;
      end else if (mOwner < 0) begin
         if (req != 0) begin
            mWin = -1;
            for (int k = 1; k <= N_REQ; k++) begin
               if (mWin < 0 && req[(mLast + k) % N_REQ]) mWin = (mLast + k) % N_REQ;
            end
            mOwner = mWin;
            mLast  = mWin;
            mSel   = mWin;
            mHold  = 1;
            mData  = wordOf(mWin);
         end
      end else if (!req[mOwner] || done[mOwner] || mHold >= MAX_HOLD) begin
         mOwner = -1;
      end else begin
         mHold = (mHold < MAX_HOLD) ? mHold + 1 : mHold;
         mData = wordOf(mOwner);
      end
   end

   // Compare process: outputs vs model every cycle, plus one-hot and fairness tracking
   int               waitCnt [N_REQ];
   logic [N_REQ-1:0] prevReq = '0;
   logic [N_REQ-1:0] prevGnt = '0;

   always @(negedge clk) begin
      if (chkEn) begin
         checkOutput("gnt", 32'(gnt), (mOwner < 0) ? 32'd0 : (32'd1 << mOwner));
         checkOutput("valid_out", 32'(valid_out), (mOwner >= 0) ? 32'd1 : 32'd0);
         checkOutput("sel", 32'(sel), 32'(mSel));
         checkOutput("data_out", 32'(data_out), 32'(mData));
         checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
         checkOutput("valid_iff_gnt", 32'(valid_out), 32'(gnt != 0));
      end
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) waitCnt[i] = 0;
      end else begin
         for (int i = 0; i < N_REQ; i++) if (!prevReq[i]) waitCnt[i] = 0;
         if (gnt != 0 && prevGnt == 0) begin
            for (int i = 0; i < N_REQ; i++) begin
               if (gnt[i]) begin
                  waitCnt[i] = 0;
               end else if (prevReq[i]) begin
                  waitCnt[i]++;
                  checkOutput("fairness", 32'(waitCnt[i] <= N_REQ - 1), 32'd1);
               end
            end
         end
      end
      prevReq = req;
      prevGnt = gnt;
   end

   // Drive one cycle's inputs shortly after the rising edge
   task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
      @(posedge clk);
      #2;
      req  = r;
      done = d;
   endtask

   // Assert reset between edges, check the asynchronous clear, then release with req preset
   task automatic resetDut(input logic [N_REQ-1:0] r);
      @(posedge clk);
      #2;
      rst  = 1'b0;
      req  = '0;
      done = '0;
      #1;
      checkOutput("rst_gnt", 32'(gnt), 32'd0);
      checkOutput("rst_valid", 32'(valid_out), 32'd0);
      checkOutput("rst_data", 32'(data_out), 32'd0);
      checkOutput("rst_sel", 32'(sel), 32'd0);
      @(posedge clk);
      #2;
      req = r;
      rst = 1'b1;
   endtask

   initial begin
      logic [N_REQ-1:0] r;
      logic [N_REQ-1:0] d;
      logic [N_REQ-1:0] expG;

      data_in = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      chkEn = 1'b1;

      // All four requesting: 8-cycle tenures, one gap cycle, rotating from requester 0
      resetDut(4'b1111);
      for (int c = 1; c <= 37; c++) begin
         @(posedge clk);
         @(negedge clk);
         expG = ((c - 1) % 9 == 8) ? 4'b0000 : (4'b0001 << (((c - 1) / 9) % 4));
         checkOutput("rr_sequence", 32'(gnt), 32'(expG));
      end

      // Single requester 2 releases with done on its third grant cycle
      data_in = {8'h11, 8'hA5, 8'h33, 8'h44};
      resetDut(4'b0100);
      for (int c = 1; c <= 5; c++) begin
         applyStimulus((c >= 4) ? 4'b0000 : 4'b0100, (c == 3) ? 4'b0100 : 4'b0000);
         @(negedge clk);
         checkOutput("done_gnt", 32'(gnt), (c <= 3) ? 32'h4 : 32'h0);
         checkOutput("done_valid", 32'(valid_out), (c <= 3) ? 32'd1 : 32'd0);
         checkOutput("done_data", 32'(data_out), 32'hA5);
      end

      // Owner 1 drops req while requester 3 waits
      resetDut(4'b0010);
      for (int c = 1; c <= 4; c++) begin
         applyStimulus((c == 1) ? 4'b0010 : 4'b1000, 4'b0000);
         @(negedge clk);
         if (c == 1) checkOutput("handoff_c1", 32'(gnt), 32'h2);
         if (c == 3) checkOutput("handoff_gap", 32'(gnt), 32'h0);
         if (c == 4) begin
            checkOutput("handoff_gnt", 32'(gnt), 32'h8);
            checkOutput("handoff_sel", 32'(sel), 32'd3);
         end
      end

      // Sole requester 0 is preempted at MAX_HOLD and re-granted after one gap cycle
      resetDut(4'b0001);
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(4'b0001, 4'b0000);
         @(negedge clk);
         checkOutput("maxhold_gnt", 32'(gnt), (c % 9 == 0) ? 32'h0 : 32'h1);
      end

      // Reset pulsed mid-grant, then released with requesters 1 and 3 pending
      resetDut(4'b0100);
      applyStimulus(4'b0100, 4'b0000);
      applyStimulus(4'b0100, 4'b0000);
      @(negedge clk);
      checkOutput("midrst_pre", 32'(gnt), 32'h4);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("midrst_gnt", 32'(gnt), 32'h0);
      checkOutput("midrst_valid", 32'(valid_out), 32'd0);
      checkOutput("midrst_data", 32'(data_out), 32'h0);
      req = 4'b1010;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_first", 32'(gnt), 32'h2);

      // Random traffic: sticky requests, occasional done pulses, fresh data every cycle
      resetDut(4'b0000);
      r = '0;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            d[i] = ($urandom_range(0, 5) == 0);
         end
         applyStimulus(r, d);
         data_in = $urandom;
      end
      @(posedge clk);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", nTotal, nBad);
      $finish;
   end

endmodule
